// File: rtl/burst_memory.sv
// Byte-addressable big-endian memory with 1/4/8/16-word bursts and a registered busy handshake.
// Optional request range/alignment checking with addr_err is enabled by defining MEM_ADDR_CHECK_EN.
module burst_memory #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DEPTH      = 1048576,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h80020000
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [1:0]            access_size,
    input  logic                  rw,
    input  logic                  enable,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid
`ifdef MEM_ADDR_CHECK_EN
    ,
    output logic                  addr_err
`endif
);

    localparam int OFF_W = $clog2(DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    state_t           next_state;
    logic [7:0]       mem [DEPTH];

    logic             rw_q;
    logic [3:0]       last_q;
    logic [3:0]       beat_cnt;
    logic [OFF_W-1:0] next_off;

    logic [ADDR_WIDTH-1:0] rel_addr;
    logic [OFF_W-1:0]      req_off;
    logic [3:0]            req_last;
    logic                  request;
    logic                  reject;
    logic                  accept;
    logic                  exec;
    logic                  exec_rw;
    logic                  exec_last;
    logic [OFF_W-1:0]      exec_off;
    logic                  unused_bits;

    // Offset wraps modulo DEPTH; the two low address bits never select a byte.
    assign rel_addr    = address - START_ADDR;
    assign req_off     = {rel_addr[OFF_W-1:2], 2'b00};
    assign unused_bits = ^{rel_addr[ADDR_WIDTH-1:OFF_W], rel_addr[1:0]};

    always_comb begin
        case (access_size)
            2'b00:   req_last = 4'd0;
            2'b01:   req_last = 4'd3;
            2'b10:   req_last = 4'd7;
            default: req_last = 4'd15;
        endcase
    end

    assign request = (state == IDLE) && enable;

`ifdef MEM_ADDR_CHECK_EN
    localparam logic [ADDR_WIDTH:0] LAST_OK = {1'b0, START_ADDR} + (ADDR_WIDTH+1)'(DEPTH - 4);

    logic [ADDR_WIDTH:0] last_addr;

    assign last_addr = {1'b0, address} + {{(ADDR_WIDTH-5){1'b0}}, req_last, 2'b00};
    assign reject    = (address[1:0] != 2'b00) || (address < START_ADDR) || (last_addr > LAST_OK);
`else
    assign reject    = 1'b0;
`endif

    assign accept = request && !reject;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Beat 0 executes on the accepting edge; later beats come from the latched burst context.
    always_comb begin
        next_state = state;
        exec       = 1'b0;
        exec_rw    = rw_q;
        exec_off   = next_off;
        exec_last  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    exec      = 1'b1;
                    exec_rw   = rw;
                    exec_off  = req_off;
                    exec_last = (req_last == 4'd0);
                    if (req_last != 4'd0) begin
                        next_state = BURST;
                    end
                end
            end
            BURST: begin
                exec      = 1'b1;
                exec_last = (beat_cnt == last_q);
                if (exec_last) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            rd_valid <= 1'b0;
            data_out <= '0;
            beat_cnt <= 4'd0;
            rw_q     <= 1'b1;
            last_q   <= 4'd0;
            next_off <= '0;
`ifdef MEM_ADDR_CHECK_EN
            addr_err <= 1'b0;
`endif
        end else begin
            busy     <= (next_state == BURST);
            rd_valid <= exec && exec_rw;
            if (exec && exec_rw) begin
                data_out <= {mem[{exec_off[OFF_W-1:2], 2'b00}],
                             mem[{exec_off[OFF_W-1:2], 2'b01}],
                             mem[{exec_off[OFF_W-1:2], 2'b10}],
                             mem[{exec_off[OFF_W-1:2], 2'b11}]};
            end
            if (accept) begin
                rw_q   <= rw;
                last_q <= req_last;
            end
            if (exec) begin
                beat_cnt <= exec_last ? 4'd0 : beat_cnt + 4'd1;
                next_off <= exec_off + OFF_W'(4);
            end
`ifdef MEM_ADDR_CHECK_EN
            addr_err <= request && reject;
`endif
        end
    end

    // Gating with reset_n keeps a held-in-reset memory from absorbing stray beats.
    always_ff @(posedge clock) begin
        if (reset_n && exec && !exec_rw) begin
            mem[{exec_off[OFF_W-1:2], 2'b00}] <= data_in[31:24];
            mem[{exec_off[OFF_W-1:2], 2'b01}] <= data_in[23:16];
            mem[{exec_off[OFF_W-1:2], 2'b10}] <= data_in[15:8];
            mem[{exec_off[OFF_W-1:2], 2'b11}] <= data_in[7:0];
        end
    end

endmodule

// File: tb/tb_burst_memory.sv
// Directed self-checking bench for burst_memory; define MEM_ADDR_CHECK_EN to exercise the checked build.
module tb_burst_memory;

    localparam logic [31:0] START = 32'h80020000;
    localparam int          DEPTH = 1048576;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  access_size = '0;
    logic        rw = 1'b0;
    logic        enable = 1'b0;
    logic        busy;
    logic [31:0] data_out;
    logic        rd_valid;
`ifdef MEM_ADDR_CHECK_EN
    logic        addr_err;
`endif

    int compared = 0;
    int mismatched = 0;

    logic [31:0] wbuf [16];
    logic [31:0] rbuf [16];
    int busy_cnt, valid_cnt, valid_first, valid_last, err_cnt;

    always #5 clock = ~clock;

    burst_memory dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .address     (address),
        .data_in     (data_in),
        .access_size (access_size),
        .rw          (rw),
        .enable      (enable),
        .busy        (busy),
        .data_out    (data_out),
        .rd_valid    (rd_valid)
`ifdef MEM_ADDR_CHECK_EN
        ,
        .addr_err    (addr_err)
`endif
    );

    function automatic logic [31:0] mem_word(input int off);
        return {dut.mem[off], dut.mem[off+1], dut.mem[off+2], dut.mem[off+3]};
    endfunction

    // One request, then N+2 cycles of monitoring; write data comes from wbuf, read beats land in rbuf.
    task automatic run_burst(input logic r, input logic [31:0] addr, input logic [1:0] size);
        int n;
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 4 : (size == 2'd2) ? 8 : 16;
        @(negedge clock);
        enable = 1'b1; rw = r; address = addr; access_size = size; data_in = wbuf[0];
        busy_cnt = 0; valid_cnt = 0; valid_first = -1; valid_last = -1; err_cnt = 0;
        for (int c = 1; c <= n + 2; c++) begin
            @(negedge clock);
            if (busy === 1'b1) busy_cnt++;
            if (rd_valid === 1'b1) begin
                if (valid_cnt < 16) rbuf[valid_cnt] = data_out;
                if (valid_first < 0) valid_first = c;
                valid_last = c;
                valid_cnt++;
            end
`ifdef MEM_ADDR_CHECK_EN
            if (addr_err === 1'b1) err_cnt++;
`endif
            enable = 1'b0;
            data_in = (c < n) ? wbuf[c] : 32'h0;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b, want 0", busy); end
        compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_rd_valid: got %b, want 0", rd_valid); end
        compared++; if (data_out !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_data_out: got %h, want 00000000", data_out); end
`ifdef MEM_ADDR_CHECK_EN
        compared++; if (addr_err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_addr_err: got %b, want 0", addr_err); end
`endif
        reset_n = 1'b1;
    endtask

    task automatic test_single;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
        wbuf[0] = 32'hDEADBEEF;
        run_burst(1'b0, START, 2'd0);
        compared++; if (busy_cnt !== 0) begin mismatched++; $display("[TB] FAIL single_wr_busy: got %0d cycles, want 0", busy_cnt); end
`ifdef MEM_ADDR_CHECK_EN
        compared++; if (err_cnt !== 0) begin mismatched++; $display("[TB] FAIL single_wr_addr_err: got %0d cycles, want 0", err_cnt); end
`endif
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (dut.mem[i] !== exp_b[i]) begin mismatched++; $display("[TB] FAIL single_byte%0d: got %h, want %h", i, dut.mem[i], exp_b[i]); end
        end
        run_burst(1'b1, START, 2'd0);
        compared++; if (busy_cnt !== 0) begin mismatched++; $display("[TB] FAIL single_rd_busy: got %0d cycles, want 0", busy_cnt); end
        compared++; if (valid_cnt !== 1) begin mismatched++; $display("[TB] FAIL single_rd_valid: got %0d cycles, want 1", valid_cnt); end
        compared++; if (rbuf[0] !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL single_rd_data: got %h, want deadbeef", rbuf[0]); end
    endtask

    task automatic test_burst4;
        logic [31:0] exp_w [4];
        exp_w[0] = 32'h11111111; exp_w[1] = 32'h22222222; exp_w[2] = 32'h33333333; exp_w[3] = 32'h44444444;
        for (int i = 0; i < 4; i++) wbuf[i] = exp_w[i];
        run_burst(1'b0, START + 32'h10, 2'd1);
        compared++; if (busy_cnt !== 3) begin mismatched++; $display("[TB] FAIL burst4_wr_busy: got %0d cycles, want 3", busy_cnt); end
        run_burst(1'b1, START + 32'h10, 2'd1);
        compared++; if (busy_cnt !== 3) begin mismatched++; $display("[TB] FAIL burst4_rd_busy: got %0d cycles, want 3", busy_cnt); end
        compared++; if (valid_cnt !== 4) begin mismatched++; $display("[TB] FAIL burst4_rd_valid: got %0d cycles, want 4", valid_cnt); end
        compared++; if (valid_last - valid_first + 1 !== 4) begin mismatched++; $display("[TB] FAIL burst4_rd_contiguous: got span %0d, want 4", valid_last - valid_first + 1); end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (rbuf[i] !== exp_w[i]) begin mismatched++; $display("[TB] FAIL burst4_rd_word%0d: got %h, want %h", i, rbuf[i], exp_w[i]); end
        end
    endtask

    task automatic test_enable_held;
        logic [31:0] a_addr;
        logic [31:0] s_addr;
        a_addr = START + 32'h100;
        s_addr = START + 32'h200;
        for (int i = 0; i < 16; i++) wbuf[i] = 32'hB0000000 | 32'(i);
        run_burst(1'b0, a_addr, 2'd3);
        compared++; if (busy_cnt !== 15) begin mismatched++; $display("[TB] FAIL held_prewrite_busy: got %0d cycles, want 15", busy_cnt); end
        wbuf[0] = 32'h0;
        run_burst(1'b0, s_addr, 2'd0);
        @(negedge clock);
        enable = 1'b1; rw = 1'b1; address = a_addr; access_size = 2'd3;
        busy_cnt = 0; valid_cnt = 0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clock);
            if (busy === 1'b1) busy_cnt++;
            if (rd_valid === 1'b1) begin
                if (valid_cnt < 16) rbuf[valid_cnt] = data_out;
                valid_cnt++;
            end
            if (c == 16) begin
                compared++;
                if (mem_word(32'h200) !== 32'h0) begin mismatched++; $display("[TB] FAIL held_early_accept: got %h, want 00000000", mem_word(32'h200)); end
            end
            if (c == 17) begin
                compared++;
                if (mem_word(32'h200) !== 32'hCAFEF00D) begin mismatched++; $display("[TB] FAIL held_next_accept: got %h, want cafef00d", mem_word(32'h200)); end
                compared++;
                if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL held_next_busy: got %b, want 0", busy); end
            end
            address = s_addr; rw = 1'b0; access_size = 2'd0; data_in = 32'hCAFEF00D;
            enable = (c < 17);
        end
        compared++; if (busy_cnt !== 15) begin mismatched++; $display("[TB] FAIL held_rd_busy: got %0d cycles, want 15", busy_cnt); end
        compared++; if (valid_cnt !== 16) begin mismatched++; $display("[TB] FAIL held_rd_valid: got %0d cycles, want 16", valid_cnt); end
        for (int i = 0; i < 16; i++) begin
            compared++;
            if (rbuf[i] !== (32'hB0000000 | 32'(i))) begin mismatched++; $display("[TB] FAIL held_rd_word%0d: got %h, want %h", i, rbuf[i], 32'hB0000000 | 32'(i)); end
        end
    endtask

    task automatic test_reset_mid_burst;
        logic [31:0] b_addr;
        logic [31:0] exp_w;
        b_addr = START + 32'h300;
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h5A000000 | 32'(i);
        run_burst(1'b0, b_addr, 2'd2);
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h77000000 | 32'(i);
        @(negedge clock);
        enable = 1'b1; rw = 1'b0; address = b_addr; access_size = 2'd2; data_in = wbuf[0];
        for (int c = 1; c <= 3; c++) begin
            @(negedge clock);
            enable = 1'b0; data_in = wbuf[c];
        end
        compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL midrst_busy_before: got %b, want 1", busy); end
        reset_n = 1'b0;
        #1;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_busy_async: got %b, want 0", busy); end
        compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL midrst_rd_valid_async: got %b, want 0", rd_valid); end
        compared++; if (data_out !== 32'h0) begin mismatched++; $display("[TB] FAIL midrst_data_out: got %h, want 00000000", data_out); end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        run_burst(1'b1, b_addr, 2'd2);
        for (int i = 0; i < 8; i++) begin
            exp_w = (i < 3) ? (32'h77000000 | 32'(i)) : (32'h5A000000 | 32'(i));
            compared++;
            if (rbuf[i] !== exp_w) begin mismatched++; $display("[TB] FAIL midrst_word%0d: got %h, want %h", i, rbuf[i], exp_w); end
        end
    endtask

    task automatic test_wrap;
        wbuf[0] = 32'h0BADF00D;
        run_burst(1'b0, START + 32'h4, 2'd0);
        wbuf[0] = 32'h12345678;
        run_burst(1'b0, START + 32'(DEPTH - 8), 2'd0);
        for (int i = 0; i < 4; i++) wbuf[i] = 32'hE0000000 | 32'(i);
        run_burst(1'b0, START + 32'(DEPTH - 8), 2'd1);
`ifdef MEM_ADDR_CHECK_EN
        compared++; if (err_cnt !== 1) begin mismatched++; $display("[TB] FAIL wrap_addr_err: got %0d cycles, want 1", err_cnt); end
        compared++; if (busy_cnt !== 0) begin mismatched++; $display("[TB] FAIL wrap_rej_busy: got %0d cycles, want 0", busy_cnt); end
        compared++; if (mem_word(DEPTH - 8) !== 32'h12345678) begin mismatched++; $display("[TB] FAIL wrap_rej_top: got %h, want 12345678", mem_word(DEPTH - 8)); end
        compared++; if (mem_word(0) !== 32'hDEADBEEF) begin mismatched++; $display("[TB] FAIL wrap_rej_off0: got %h, want deadbeef", mem_word(0)); end
        compared++; if (mem_word(4) !== 32'h0BADF00D) begin mismatched++; $display("[TB] FAIL wrap_rej_off4: got %h, want 0badf00d", mem_word(4)); end
`else
        compared++; if (busy_cnt !== 3) begin mismatched++; $display("[TB] FAIL wrap_wr_busy: got %0d cycles, want 3", busy_cnt); end
        compared++; if (mem_word(0) !== 32'hE0000002) begin mismatched++; $display("[TB] FAIL wrap_off0: got %h, want e0000002", mem_word(0)); end
        run_burst(1'b1, START + 32'(DEPTH - 8), 2'd1);
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (rbuf[i] !== (32'hE0000000 | 32'(i))) begin mismatched++; $display("[TB] FAIL wrap_rd_word%0d: got %h, want %h", i, rbuf[i], 32'hE0000000 | 32'(i)); end
        end
`endif
    endtask

    task automatic test_back_to_back;
        @(negedge clock);
        enable = 1'b1; rw = 1'b0; address = START + 32'h400; access_size = 2'd0; data_in = 32'h600DCAFE;
        @(negedge clock);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_busy: got %b, want 0", busy); end
        rw = 1'b1; data_in = 32'h0;
        @(negedge clock);
        enable = 1'b0;
        compared++; if (rd_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_rd_valid: got %b, want 1", rd_valid); end
        compared++; if (data_out !== 32'h600DCAFE) begin mismatched++; $display("[TB] FAIL b2b_data: got %h, want 600dcafe", data_out); end
        @(negedge clock);
        compared++; if (rd_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_rd_valid_drop: got %b, want 0", rd_valid); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_burst4();
        test_enable_held();
        test_reset_mid_burst();
        test_wrap();
        test_back_to_back();
        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
